// File: rtl/misao_pc_unit.sv
// Next-PC and control-transfer unit: sequential advance, scaled relative branches, jumps and a circular return-address stack.
// All outputs registered one cycle after the sampling edge; stall freezes every piece of state and only clears taken.
module misao_pc_unit #(
    parameter int              PC_W      = 16,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           stall_i,
    input  logic [1:0]                     adv_i,
    input  logic                           br_valid_i,
    input  logic [2:0]                     br_cond_i,
    input  logic [OFF_W-1:0]               br_off_i,
    input  logic [1:0]                     br_shift_i,
    input  logic                           acc_zero_i,
    input  logic                           carry_i,
    input  logic                           acc_neg_i,
    input  logic                           jmp_valid_i,
    input  logic                           jal_i,
    input  logic [PC_W-1:0]                jmp_target_i,
    input  logic                           ret_valid_i,
    output logic [PC_W-1:0]                pc_o,
    output logic                           taken_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_o,
    output logic                           ras_ovf_o,
    output logic                           ras_udf_o
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic [PC_W-1:0]  pc_seq, off_ext, br_tgt;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;
    logic             cond_true, ras_empty, ras_full, push;

    assign pc_seq    = pc_q + PC_W'(adv_i);
    assign off_ext   = PC_W'($signed(br_off_i));
    assign br_tgt    = pc_seq + (off_ext << br_shift_i);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // ptr_q is the next write slot; the top of stack sits one slot behind it.
    assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond_i)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = acc_zero_i;
            3'd2:    cond_true = !acc_zero_i;
            3'd3:    cond_true = carry_i;
            3'd4:    cond_true = !carry_i;
            3'd5:    cond_true = acc_neg_i;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push    = 1'b0;
        if (!stall_i) begin
            pc_d = pc_seq;
            if (ret_valid_i) begin
                if (!ras_empty) begin
                    pc_d    = ras_q[ptr_dec];
                    taken_d = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    ptr_d   = ptr_dec;
                end else begin
                    udf_d = 1'b1;
                end
            end else if (jmp_valid_i) begin
                pc_d    = jmp_target_i;
                taken_d = 1'b1;
                if (jal_i) begin
                    // When full the write slot holds the oldest entry, so it is simply overwritten.
                    push  = 1'b1;
                    ptr_d = ptr_inc;
                    if (ras_full) ovf_d = 1'b1;
                    else          cnt_d = cnt_q + 1'b1;
                end
            end else if (br_valid_i && cond_true) begin
                pc_d    = br_tgt;
                taken_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) ras_q[ptr_q] <= pc_seq;
    end

    assign pc_o        = pc_q;
    assign taken_o     = taken_q;
    assign ras_count_o = cnt_q;
    assign ras_ovf_o   = ovf_q;
    assign ras_udf_o   = udf_q;
endmodule

// File: tb/tb_misao_pc_unit.sv
// Directed-vector bench for misao_pc_unit with default parameters (PC_W=16, RAS_DEPTH=4, RESET_PC=0).
module tb_misao_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, br_valid, acc_zero, carry, acc_neg, jmp_valid, jal, ret_valid;
    logic [1:0]  adv, br_shift;
    logic [2:0]  br_cond;
    logic [7:0]  br_off;
    logic [15:0] jmp_target;
    logic [15:0] pc;
    logic        taken, ras_ovf, ras_udf;
    logic [2:0]  ras_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    misao_pc_unit dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .adv_i(adv),
        .br_valid_i(br_valid), .br_cond_i(br_cond), .br_off_i(br_off), .br_shift_i(br_shift),
        .acc_zero_i(acc_zero), .carry_i(carry), .acc_neg_i(acc_neg),
        .jmp_valid_i(jmp_valid), .jal_i(jal), .jmp_target_i(jmp_target), .ret_valid_i(ret_valid),
        .pc_o(pc), .taken_o(taken), .ras_count_o(ras_count), .ras_ovf_o(ras_ovf), .ras_udf_o(ras_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        rst = 0; stall = 0; adv = 0; br_valid = 0; br_cond = 0; br_off = 0; br_shift = 0;
        acc_zero = 0; carry = 0; acc_neg = 0; jmp_valid = 0; jal = 0; jmp_target = 0; ret_valid = 0;
    endtask

    // Apply the current inputs for one edge, sample 1 time unit later, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_jmp(input logic [15:0] tgt, input logic with_link, input logic [1:0] a);
        jmp_valid = 1; jmp_target = tgt; jal = with_link; adv = a;
        tick();
    endtask

    task automatic do_br(input logic [2:0] c, input logic [7:0] off, input logic [1:0] sh, input logic [1:0] a);
        br_valid = 1; br_cond = c; br_off = off; br_shift = sh; adv = a;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        check("rst_pc", pc, 0);
        check("rst_taken", taken, 0);
        check("rst_cnt", ras_count, 0);
        check("rst_ovf", ras_ovf, 0);
        check("rst_udf", ras_udf, 0);

        adv = 2; tick();
        adv = 2; tick();
        check("seq_adv", pc, 16'h0004);

        do_br(3'd1, 8'd2, 2'd0, 2'd1); acc_zero = 1; tick();
        check("br_taken_pc", pc, 16'h0007);
        check("br_taken_pulse", taken, 1);
        tick();
        check("br_taken_end", taken, 0);
        check("hold_adv0", pc, 16'h0007);

        adv = 1; tick();
        do_br(3'd1, 8'd2, 2'd0, 2'd1); acc_zero = 0; tick();
        check("br_nt_pc", pc, 16'h0009);
        check("br_nt_taken", taken, 0);

        do_jmp(16'h002E, 0, 2'd3);
        check("jmp_pc", pc, 16'h002E);
        check("jmp_taken", taken, 1);
        do_br(3'd0, 8'hFF, 2'd1, 2'd1); tick();
        check("br_neg_scaled", pc, 16'h002D);

        do_br(3'd6, 8'd5, 2'd0, 2'd1); tick();
        check("br_never_pc", pc, 16'h002E);
        check("br_never_taken", taken, 0);
        do_br(3'd3, 8'd4, 2'd2, 2'd1); carry = 1; tick();
        check("br_carry_shift2", pc, 16'h003F);
        do_br(3'd5, 8'd4, 2'd0, 2'd0); acc_neg = 0; tick();
        check("br_neg_false", pc, 16'h003F);

        do_jmp(16'hFFFE, 0, 2'd0);
        adv = 3; tick();
        check("wrap_fwd", pc, 16'h0001);
        do_br(3'd0, 8'hFE, 2'd0, 2'd0); tick();
        check("wrap_back", pc, 16'hFFFF);

        do_jmp(16'h0010, 0, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            do_jmp(16'((i + 1) * 16), 1, 2'd1);
            check("jal_pc", pc, 32'((i + 1) * 16));
            check("jal_cnt", ras_count, (i < 4) ? i : 4);
            check("jal_ovf", ras_ovf, (i == 5) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1; tick();
            check("ret_pc", pc, 32'(16'h0051 - 16 * i));
            check("ret_taken", taken, 1);
            check("ret_cnt", ras_count, 3 - i);
        end
        check("udf_before", ras_udf, 0);
        ret_valid = 1; adv = 1; tick();
        check("udf_pc", pc, 16'h0022);
        check("udf_taken", taken, 0);
        check("udf_flag", ras_udf, 1);
        check("udf_cnt", ras_count, 0);
        check("ovf_sticky", ras_ovf, 1);

        do_jmp(16'h0400, 1, 2'd2);
        check("prio_setup_cnt", ras_count, 1);
        ret_valid = 1; jmp_valid = 1; jal = 1; jmp_target = 16'h0500; tick();
        check("prio_ret_pc", pc, 16'h0024);
        check("prio_ret_cnt", ras_count, 0);
        check("prio_ret_taken", taken, 1);

        stall = 1; do_br(3'd0, 8'd5, 2'd0, 2'd1); tick();
        check("stall_pc", pc, 16'h0024);
        check("stall_taken", taken, 0);
        check("stall_udf", ras_udf, 1);
        stall = 1; jmp_valid = 1; jal = 1; jmp_target = 16'h0600; tick();
        check("stall_jal_cnt", ras_count, 0);
        check("stall_jal_pc", pc, 16'h0024);

        do_jmp(16'h0700, 1, 2'd1);
        check("pre_rst_cnt", ras_count, 1);
        rst = 1; jmp_valid = 1; jal = 1; jmp_target = 16'h0800; adv = 1; tick();
        check("rst_jal_pc", pc, 0);
        check("rst_jal_cnt", ras_count, 0);
        check("rst_jal_taken", taken, 0);
        check("rst_jal_ovf", ras_ovf, 0);
        check("rst_jal_udf", ras_udf, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
